if_id_skid_register: RTL

//  IF/ID pipeline boundary of the MIPS core. Buffers {PC+4, instruction} from fetch behind a

---
 rtl/mips_pkg.sv | 51 +++++
 rtl/if_id_field_split.sv | 19 +
 rtl/if_id_skid_register.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS-I field layout and IF/ID bundle types for the pipeline registers.
package mips_pkg;

    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int SHAMT_MSB  = 10;
    localparam int SHAMT_LSB  = 6;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;

    localparam int OPCODE_W = OPCODE_MSB - OPCODE_LSB + 1;
    localparam int REG_W    = RS_MSB - RS_LSB + 1;
    localparam int FUNCT_W  = FUNCT_MSB - FUNCT_LSB + 1;
    localparam int IMM_W    = IMM_MSB - IMM_LSB + 1;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [PC_W-1:0]    pc4;
        logic [INSTR_W-1:0] instr;
    } if_id_entry_t;

    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [REG_W-1:0]    rs;
        logic [REG_W-1:0]    rt;
        logic [REG_W-1:0]    rd;
        logic [REG_W-1:0]    shamt;
        logic [FUNCT_W-1:0]  funct;
        logic [IMM_W-1:0]    imm16;
    } id_fields_t;

    // Word offset of a branch: sign-extended and scaled by 4.
    function automatic logic [PC_W-1:0] branch_offset(
        input logic [IMM_W-1:0] imm
    );
        return {{(PC_W-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/if_id_field_split.sv
// Combinational MIPS-I field slicer; shared by the IF/ID and ID/EX registers.
module if_id_field_split
    import mips_pkg::*;
(
    input  logic [INSTR_W-1:0] instr_i,
    output id_fields_t         fields_o
);

    always_comb begin
        fields_o.opcode = instr_i[OPCODE_MSB:OPCODE_LSB];
        fields_o.rs     = instr_i[RS_MSB:RS_LSB];
        fields_o.rt     = instr_i[RT_MSB:RT_LSB];
        fields_o.rd     = instr_i[RD_MSB:RD_LSB];
        fields_o.shamt  = instr_i[SHAMT_MSB:SHAMT_LSB];
        fields_o.funct  = instr_i[FUNCT_MSB:FUNCT_LSB];
        fields_o.imm16  = instr_i[IMM_MSB:IMM_LSB];
    end

endmodule

// File: rtl/if_id_skid_register.sv
// IF/ID register with a 2-entry skid behind a valid/ready handshake.
// Define IF_ID_BRANCH_TARGET_EN to compute branch_target_o from the head entry.
module if_id_skid_register
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int PC_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [PC_WIDTH-1:0]   in_pc4_i,
    input  logic [DATA_WIDTH-1:0] in_instr_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [PC_WIDTH-1:0]   pc4_o,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [5:0]            opcode_o,
    output logic [4:0]            rs_o,
    output logic [4:0]            rt_o,
    output logic [4:0]            rd_o,
    output logic [4:0]            shamt_o,
    output logic [5:0]            funct_o,
    output logic [15:0]           imm16_o,
    output logic [PC_WIDTH-1:0]   branch_target_o
);

    if_id_entry_t head_q, head_d;
    if_id_entry_t skid_q, skid_d;
    logic         head_valid_q, head_valid_d;
    logic         skid_valid_q, skid_valid_d;

    if_id_entry_t in_entry;
    if_id_entry_t head_out;
    id_fields_t   fields;
    logic         push;
    logic         pop;

    assign in_entry.pc4   = in_pc4_i;
    assign in_entry.instr = in_instr_i;

    // Readiness comes straight from a flop so fetch never sees decode's stall path.
    assign in_ready_o  = ~skid_valid_q;
    assign out_valid_o = head_valid_q;

    assign push = in_valid_i & ~skid_valid_q;
    assign pop  = head_valid_q & out_ready_i;

    always_comb begin
        head_d       = head_q;
        skid_d       = skid_q;
        head_valid_d = head_valid_q;
        skid_valid_d = skid_valid_q;

        if (flush_i) begin
            head_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!head_valid_q) begin
            if (push) begin
                head_d       = in_entry;
                head_valid_d = 1'b1;
            end
        end else if (pop) begin
            if (skid_valid_q) begin
                head_d       = skid_q;
                skid_valid_d = 1'b0;
            end else if (push) begin
                head_d = in_entry;
            end else begin
                head_valid_d = 1'b0;
            end
        end else if (push) begin
            skid_d       = in_entry;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q       <= '0;
            skid_q       <= '0;
            head_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            head_q       <= head_d;
            skid_q       <= skid_d;
            head_valid_q <= head_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    // An empty head shows a NOP so decode sees a harmless bubble.
    always_comb begin
        head_out = '0;
        head_out.instr = NOP_INSTR;
        if (head_valid_q) begin
            head_out = head_q;
        end
    end

    assign pc4_o   = head_out.pc4;
    assign instr_o = head_out.instr;

    if_id_field_split u_split (
        .instr_i  (instr_o),
        .fields_o (fields)
    );

    assign opcode_o = fields.opcode;
    assign rs_o     = fields.rs;
    assign rt_o     = fields.rt;
    assign rd_o     = fields.rd;
    assign shamt_o  = fields.shamt;
    assign funct_o  = fields.funct;
    assign imm16_o  = fields.imm16;

`ifdef IF_ID_BRANCH_TARGET_EN
    assign branch_target_o = pc4_o + branch_offset(imm16_o);
`else
    assign branch_target_o = '0;
`endif

endmodule
